// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Owns the program counter and drives instruction fetch. The current PC is
//   issued to instruction memory over a req/gnt + rvalid handshake. Each
//   returned word is held for decode under a valid/ready handshake. A one-cycle
//   PCSrc strobe from execute redirects the PC to BranchAdd at any time.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   PCSrc, BranchAdd   redirect strobe and target (low two target bits dropped)
//   imem_req/addr      fetch request and address (address is always the PC)
//   imem_gnt           memory accepts the request this cycle
//   imem_rvalid/rdata  returned instruction word
//   instr_valid/instr  held instruction for decode
//   instr_pc, PCPlus4  address of held instruction and that address + 4
//   instr_ready        decode consumes the held instruction
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int unsigned           DataWidth   = 32,
    parameter logic [DataWidth-1:0]  ResetVector = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 PCSrc,
    input  logic [DataWidth-1:0] BranchAdd,
    output logic                 imem_req,
    output logic [DataWidth-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [DataWidth-1:0] imem_rdata,
    output logic                 instr_valid,
    output logic [DataWidth-1:0] instr,
    output logic [DataWidth-1:0] instr_pc,
    output logic [DataWidth-1:0] PCPlus4,
    input  logic                 instr_ready
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e               state_q;
    logic [DataWidth-1:0] pc_q;
    logic                 kill_q;      // in-flight response belongs to a squashed fetch
    logic                 req_q;       // set exactly while in StReq
    logic                 valid_q;     // set exactly while in StHold
    logic [DataWidth-1:0] instr_q;
    logic [DataWidth-1:0] instr_pc_q;
    logic [DataWidth-1:0] pcplus4_q;

    logic [DataWidth-1:0] pc_plus4;
    logic [DataWidth-1:0] branch_tgt;

    // Wraps modulo 2^DataWidth.
    assign pc_plus4   = pc_q + DataWidth'(4);
    // Targets are word aligned.
    assign branch_tgt = BranchAdd & ~{{(DataWidth-2){1'b0}}, 2'b11};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= ResetVector;
            kill_q     <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            pcplus4_q  <= DataWidth'(4);
        end else begin
            case (state_q)
                StIdle: begin
                    state_q <= StReq;
                    req_q   <= 1'b1;
                    if (PCSrc) pc_q <= branch_tgt;
                end

                StReq: begin
                    // A redirect masks the request, so a coincident gnt is void.
                    if (PCSrc) begin
                        pc_q <= branch_tgt;
                    end else if (imem_gnt) begin
                        state_q <= StWait;
                        req_q   <= 1'b0;
                    end
                end

                StWait: begin
                    if (imem_rvalid) begin
                        if (PCSrc || kill_q) begin
                            // Response belongs to a squashed fetch: drop it.
                            state_q <= StReq;
                            req_q   <= 1'b1;
                            kill_q  <= 1'b0;
                            if (PCSrc) pc_q <= branch_tgt;
                        end else begin
                            state_q    <= StHold;
                            valid_q    <= 1'b1;
                            instr_q    <= imem_rdata;
                            instr_pc_q <= pc_q;
                            pcplus4_q  <= pc_plus4;
                            pc_q       <= pc_plus4;
                        end
                    end else if (PCSrc) begin
                        // Must still wait for the outstanding response.
                        pc_q   <= branch_tgt;
                        kill_q <= 1'b1;
                    end
                end

                StHold: begin
                    if (PCSrc || instr_ready) begin
                        state_q <= StReq;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                        if (PCSrc) pc_q <= branch_tgt;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // The redirect strobe suppresses the request in the same cycle.
    assign imem_req    = req_q & ~PCSrc;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign PCPlus4     = pcplus4_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Self-checking bench for pc_fetch_unit: directed scenarios followed by a
//   randomized run checked against a transaction-level fetch model.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCSrc;
    logic [31:0] BranchAdd;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] PCPlus4;
    logic        instr_ready;

    int asserts  = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .DataWidth   (32),
        .ResetVector (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCSrc       (PCSrc),
        .BranchAdd   (BranchAdd),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .PCPlus4     (PCPlus4),
        .instr_ready (instr_ready)
    );

    // Memory contents as a function of address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    task automatic idle_inputs();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        BranchAdd   = '0;
    endtask

    // Drive one cycle of inputs, clock, then return inputs to idle.
    // Returns at posedge + 2 with outputs settled.
    task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                        input logic rdy, input logic ps, input logic [31:0] ba);
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rd;
        instr_ready = rdy;
        PCSrc       = ps;
        BranchAdd   = ba;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
    endtask

    // Release reset; the IDLE cycle passes and the DUT sits in REQ.
    task automatic release_reset();
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        apply_reset();
        asserts++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imem_req); end
        asserts++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        asserts++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        asserts++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h want 0", instr); end
        asserts++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        asserts++; if (PCPlus4 !== 32'h4) begin failures++; $display("FAIL reset_pcplus4: got %h want 4", PCPlus4); end
        // Still in IDLE on the first released cycle: no request yet.
        rst_n = 1'b1;
        #1;
        asserts++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req: got %b want 0", imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        apply_reset();
        release_reset();
        for (int k = 0; k < 3; k++) begin
            a = 32'(k) * 4;
            asserts++; if (imem_req !== 1'b1) begin failures++; $display("FAIL seq_req k=%0d: got %b want 1", k, imem_req); end
            asserts++; if (imem_addr !== a) begin failures++; $display("FAIL seq_addr k=%0d: got %h want %h", k, imem_addr, a); end
            step(1, 0, 0, 0, 0, 0);
            asserts++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL seq_wait k=%0d: got req=%b valid=%b want 0/0", k, imem_req, instr_valid); end
            step(0, 1, word_at(a), 0, 0, 0);
            asserts++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL seq_valid k=%0d: got %b want 1", k, instr_valid); end
            asserts++; if (instr !== word_at(a)) begin failures++; $display("FAIL seq_instr k=%0d: got %h want %h", k, instr, word_at(a)); end
            asserts++; if (instr_pc !== a) begin failures++; $display("FAIL seq_instr_pc k=%0d: got %h want %h", k, instr_pc, a); end
            asserts++; if (PCPlus4 !== a + 4) begin failures++; $display("FAIL seq_pcplus4 k=%0d: got %h want %h", k, PCPlus4, a + 4); end
            step(0, 0, 0, 1, 0, 0);
        end
    endtask

    task automatic test_gnt_stall();
        apply_reset();
        release_reset();
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 1, 0, 0);
            asserts++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL stall_req k=%0d: got req=%b addr=%h want 1/0", k, imem_req, imem_addr); end
            asserts++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stall_valid k=%0d: got %b want 0", k, instr_valid); end
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        release_reset();
        // Redirect in WAIT with no response yet: the late response is dropped.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h100);
        asserts++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL rdw_kill: got req=%b valid=%b want 0/0", imem_req, instr_valid); end
        step(0, 1, word_at(0), 1, 0, 0);
        asserts++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rdw_drop: got valid %b want 0", instr_valid); end
        asserts++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL rdw_addr: got req=%b addr=%h want 1/100", imem_req, imem_addr); end
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, word_at(32'h100), 0, 0, 0);
        asserts++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== word_at(32'h100)) begin failures++; $display("FAIL rdw_fetch: got valid=%b pc=%h instr=%h want 1/100/%h", instr_valid, instr_pc, instr, word_at(32'h100)); end
        // Redirect coincident with the response.
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, word_at(32'h104), 0, 1, 32'h300);
        asserts++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin failures++; $display("FAIL rdw_same: got valid=%b req=%b addr=%h want 0/1/300", instr_valid, imem_req, imem_addr); end
        // Redirect in REQ masks the request and voids a coincident gnt.
        imem_gnt  = 1'b1;
        PCSrc     = 1'b1;
        BranchAdd = 32'h400;
        #1;
        asserts++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rdr_mask: got req %b want 0", imem_req); end
        step(1, 0, 0, 0, 1, 32'h400);
        asserts++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin failures++; $display("FAIL rdr_addr: got req=%b addr=%h want 1/400", imem_req, imem_addr); end
    endtask

    task automatic test_hold_stall();
        apply_reset();
        release_reset();
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, word_at(0), 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 0);
            asserts++; if (instr_valid !== 1'b1 || instr !== word_at(0) || instr_pc !== 32'h0) begin failures++; $display("FAIL hold_stable k=%0d: got valid=%b instr=%h pc=%h want 1/%h/0", k, instr_valid, instr, instr_pc, word_at(0)); end
            asserts++; if (imem_req !== 1'b0) begin failures++; $display("FAIL hold_req k=%0d: got %b want 0", k, imem_req); end
        end
        step(0, 0, 0, 1, 1, 32'h203);
        asserts++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL hold_drop: got %b want 0", instr_valid); end
        asserts++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL hold_redir: got req=%b addr=%h want 1/200", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        apply_reset();
        release_reset();
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        asserts++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, word_at(32'hFFFF_FFFC), 0, 0, 0);
        asserts++; if (instr_pc !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin failures++; $display("FAIL wrap_pcplus4: got pc=%h plus4=%h want fffffffc/0", instr_pc, PCPlus4); end
        step(0, 0, 0, 1, 0, 0);
        asserts++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid_fetch();
        apply_reset();
        release_reset();
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, word_at(0), 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // In WAIT for address 4; assert reset between edges.
        #1;
        rst_n = 1'b0;
        #1;
        asserts++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_ctl: got req=%b addr=%h valid=%b want 0/0/0", imem_req, imem_addr, instr_valid); end
        asserts++; if (instr !== 32'h0 || instr_pc !== 32'h0 || PCPlus4 !== 32'h4) begin failures++; $display("FAIL mid_rst_data: got instr=%h pc=%h plus4=%h want 0/0/4", instr, instr_pc, PCPlus4); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(0, 1, word_at(4), 1, 0, 0);
        step(0, 1, word_at(4), 1, 0, 0);
        asserts++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL mid_stray: got valid=%b req=%b addr=%h want 0/1/0", instr_valid, imem_req, imem_addr); end
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, word_at(0), 0, 0, 0);
        asserts++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== word_at(0)) begin failures++; $display("FAIL mid_refetch: got valid=%b pc=%h instr=%h want 1/0/%h", instr_valid, instr_pc, instr, word_at(0)); end
    endtask

    // Randomized run against a transaction model: the expected next fetch
    // address, a queue of granted fetches (with a squashed flag), and the
    // instruction currently offered to decode.
    task automatic test_random();
        logic [31:0] exp_addr;
        logic [31:0] infl_q[$];
        bit          stale_q[$];
        bit          exp_valid;
        logic [31:0] hold_addr;
        bit          exp_req;
        logic        g, rv, rdy, ps;
        logic [31:0] ba, a;
        bit          st;

        apply_reset();
        release_reset();
        exp_addr  = 32'h0;
        exp_valid = 1'b0;
        hold_addr = 32'h0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            g   = ($urandom_range(0, 3) != 0);
            rv  = (infl_q.size() > 0) && ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 1) != 0);
            ps  = ($urandom_range(0, 11) == 0);
            ba  = $urandom;
            if ($urandom_range(0, 7) == 0) ba = 32'hFFFF_FFF0 | (ba & 32'hF);

            imem_gnt    = g;
            imem_rvalid = rv;
            imem_rdata  = rv ? word_at(infl_q[0]) : $urandom;
            instr_ready = rdy;
            PCSrc       = ps;
            BranchAdd   = ba;
            #1;

            exp_req = !exp_valid && (infl_q.size() == 0) && !ps;
            asserts++; if (imem_req !== exp_req) begin failures++; $display("FAIL rnd_req cyc=%0d: got %b want %b", cyc, imem_req, exp_req); end
            asserts++; if (imem_addr !== exp_addr) begin failures++; $display("FAIL rnd_addr cyc=%0d: got %h want %h", cyc, imem_addr, exp_addr); end
            asserts++; if (instr_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d: got %b want %b", cyc, instr_valid, exp_valid); end
            if (exp_valid) begin
                asserts++; if (instr !== word_at(hold_addr) || instr_pc !== hold_addr || PCPlus4 !== hold_addr + 32'd4) begin failures++; $display("FAIL rnd_data cyc=%0d: got instr=%h pc=%h plus4=%h want %h/%h/%h", cyc, instr, instr_pc, PCPlus4, word_at(hold_addr), hold_addr, hold_addr + 32'd4); end
            end

            // Effects of this clock edge.
            if (ps) begin
                exp_addr  = ba & ~32'h3;
                exp_valid = 1'b0;
                for (int i = 0; i < stale_q.size(); i++) stale_q[i] = 1'b1;
            end else if (exp_valid && rdy) begin
                exp_valid = 1'b0;
            end
            if (exp_req && g) begin
                infl_q.push_back(exp_addr);
                stale_q.push_back(1'b0);
            end
            if (rv) begin
                a  = infl_q.pop_front();
                st = stale_q.pop_front();
                if (!st) begin
                    exp_valid = 1'b1;
                    hold_addr = a;
                    exp_addr  = a + 32'd4;
                end
            end

            @(posedge clk);
            #1;
            idle_inputs();
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_gnt_stall();
        test_redirect();
        test_hold_stall();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1);
    end

endmodule
